// File: rtl/pipe_shifter.sv
// Two-stage pipelined barrel shifter (LSL/LSR/ASR/ROR/RRX) with carry-out.
// It uses a valid/ready handshake on both sides and supports flush.
module pipe_shifter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AMT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic [2:0]       in_op,
   input  logic             in_carry,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry
);

   localparam int unsigned LOG2W = $clog2(WIDTH);
   localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

   typedef enum logic [1:0] {
      OP_LSL = 2'b00,
      OP_LSR = 2'b01,
      OP_ASR = 2'b10,
      OP_ROR = 2'b11
   } shift_op_e;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             carry;
      shift_op_e        op;
      logic             reg_mode;
      logic [AMT_W-1:0] amt;
   } s1_t;

   logic             s1_valid;
   s1_t              s1;
   s1_t              s1_next;
   logic             s2_advance;
   logic [WIDTH-1:0] res_data;
   logic             res_carry;

   logic [WIDTH:0]        lsl_w;
   logic [WIDTH:0]        lsr_w;
   logic signed [WIDTH:0] asr_w;
   logic [AMT_W-1:0]      asr_amt;
   logic [LOG2W-1:0]      rot;
   logic [WIDTH-1:0]      ror_d;

   // Handshake: in_ready is held low during reset and flush.
   always_comb begin
      s2_advance = !out_valid | out_ready;
      in_ready   = rst_n & !flush & (!s1_valid | s2_advance);
   end

   // Normalise the amount; an immediate zero means a full-width shift for LSR/ASR.
   always_comb begin
      s1_next.data     = in_data;
      s1_next.carry    = in_carry;
      s1_next.op       = shift_op_e'(in_op[2:1]);
      s1_next.reg_mode = in_op[0];
      s1_next.amt      = in_amt;
      if (!in_op[0]) begin
         s1_next.amt = AMT_W'(in_amt[LOG2W-1:0]);
         if (in_amt[LOG2W-1:0] == '0 &&
             (s1_next.op == OP_LSR || s1_next.op == OP_ASR))
            s1_next.amt = W_AMT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid)
            s1 <= s1_next;
      end
   end

   // Extended-width shifts produce the carry bit alongside the result.
   always_comb begin
      rot     = s1.amt[LOG2W-1:0];
      lsl_w   = {1'b0, s1.data} << s1.amt;
      lsr_w   = {s1.data, 1'b0} >> s1.amt;
      asr_amt = (s1.amt > W_AMT) ? W_AMT : s1.amt;
      asr_w   = $signed({s1.data, 1'b0}) >>> asr_amt;
      ror_d   = WIDTH'({s1.data, s1.data} >> rot);

      res_data  = s1.data;
      res_carry = s1.carry;
      case (s1.op)
         OP_LSL: if (s1.amt != '0) {res_carry, res_data} = lsl_w;
         OP_LSR: if (s1.amt != '0) {res_data, res_carry} = lsr_w;
         OP_ASR: if (s1.amt != '0) {res_data, res_carry} = asr_w;
         OP_ROR: begin
            if (s1.amt == '0) begin
               if (!s1.reg_mode)
                  {res_data, res_carry} = {s1.carry, s1.data};
            end else begin
               res_data  = ror_d;
               res_carry = ror_d[WIDTH-1];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_carry <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (s2_advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data  <= res_data;
            out_carry <= res_carry;
         end
      end
   end

endmodule
